// File: rtl/bsearch_sequencer.sv
// bsearch_sequencer: binary-search sequencer over a sorted synchronous-read RAM,
// pacing each probe to the RAM read latency and reporting hit address and probe count.
module bsearch_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] target,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] result_addr,
  output logic [3:0]        probes
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMPARE, DONE} state_t;
  localparam logic [ADDR_W:0] HI_MAX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  state_t state_q, state_d;
  logic [ADDR_W:0] low_q, low_d, high_q, high_d, mid_x, lo_n, hi_n;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic found_q, found_d;
  logic [ADDR_W-1:0] res_q, res_d, mid;
  logic [3:0] probes_q, probes_d;
  // bounds are one bit wider so low can step past the top address without wrapping
  assign mid = ADDR_W'(({1'b0, low_q} + {1'b0, high_q}) >> 1);
  assign mid_x = {1'b0, mid};
  assign lo_n = mid_x + ONE;
  assign hi_n = mid_x - ONE;
  always_comb begin
    state_d = state_q;
    low_d = low_q;
    high_d = high_q;
    tgt_d = tgt_q;
    wcnt_d = wcnt_q;
    found_d = found_q;
    res_d = res_q;
    probes_d = probes_q;
    case (state_q)
      IDLE: if (start) begin
        tgt_d = target;
        probes_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        wcnt_d = 3'(RD_LAT - 1);
        state_d = (RD_LAT == 1) ? COMPARE : WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q - 3'd1;
        state_d = (wcnt_q == 3'd1) ? COMPARE : WAIT;
      end
      COMPARE: begin
        probes_d = (probes_q == 4'd15) ? probes_q : probes_q + 4'd1;
        if (mem_rdata == tgt_q) begin
          res_d = mid;
          found_d = 1'b1;
          state_d = DONE;
        end else if (mem_rdata > tgt_q) begin
          high_d = (mid == '0) ? high_q : hi_n;
          state_d = (mid == '0 || low_q > hi_n) ? DONE : ISSUE;
        end else begin
          low_d = lo_n;
          state_d = (lo_n > high_q) ? DONE : ISSUE;
        end
      end
      DONE: state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    if (state_d == IDLE) begin
      low_d = '0;
      high_d = HI_MAX;
      found_d = 1'b0;
      res_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      low_q <= '0;
      high_q <= HI_MAX;
      tgt_q <= '0;
      wcnt_q <= '0;
      found_q <= 1'b0;
      res_q <= '0;
      probes_q <= '0;
    end else begin
      state_q <= state_d;
      low_q <= low_d;
      high_q <= high_d;
      tgt_q <= tgt_d;
      wcnt_q <= wcnt_d;
      found_q <= found_d;
      res_q <= res_d;
      probes_q <= probes_d;
    end
  end
  assign mem_addr = mid;
  assign busy = (state_q == ISSUE) || (state_q == WAIT) || (state_q == COMPARE);
  assign done = (state_q == DONE);
  assign found = found_q;
  assign result_addr = res_q;
  assign probes = probes_q;
endmodule

// File: tb/tb_bsearch_sequencer.sv
// tb_bsearch_sequencer: three sequencers (read latency 1..3) share stimulus; a scoreboard
// per instance checks each finished search against a plain integer binary-search model.
module tb_bsearch_sequencer;
  typedef struct {bit f; int a; int p; int t0;} exp_t;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [7:0] target = 0;
  logic [7:0] mem [32];
  logic [4:0] ma [3], ra [3];
  logic [7:0] rd [3];
  logic bz [3], dn [3], fd [3];
  logic [3:0] pr [3];
  exp_t q [3][$];
  int cyc = 0, errors = 0, checks = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  function automatic exp_t model(input int t);
    int lo = 0, hi = 31, m;
    exp_t e = '{0, 0, 0, 0};
    while (lo <= hi) begin
      m = (lo + hi) / 2;
      e.p++;
      if (int'(mem[m]) == t) begin
        e.f = 1;
        e.a = m;
        break;
      end
      if (int'(mem[m]) > t) hi = m - 1; else lo = m + 1;
    end
    return e;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : gl
    localparam int L = g + 1;
    logic [7:0] pipe [L];
    logic dprev = 0;
    exp_t e;
    always @(posedge clk) begin
      pipe[0] <= mem[ma[g]];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign rd[g] = pipe[L-1];
    bsearch_sequencer #(.ADDR_W(5), .DATA_W(8), .RD_LAT(L)) dut (
      .clk(clk), .reset(rst), .start(start), .abort(abort), .target(target),
      .mem_addr(ma[g]), .mem_rdata(rd[g]), .busy(bz[g]), .done(dn[g]), .found(fd[g]),
      .result_addr(ra[g]), .probes(pr[g]));
    always @(negedge clk) begin
      if (!rst && dn[g] && !dprev) begin
        if (q[g].size() == 0) chk($sformatf("unexpected_done_lat%0d", L), 1, 0);
        else begin
          e = q[g].pop_front();
          chk($sformatf("found_lat%0d", L), int'(fd[g]), int'(e.f));
          chk($sformatf("result_addr_lat%0d", L), int'(ra[g]), e.a);
          chk($sformatf("probes_lat%0d", L), int'(pr[g]), e.p);
          chk($sformatf("done_latency_lat%0d", L), cyc - e.t0, e.p * (L + 1));
          chk($sformatf("busy_in_done_lat%0d", L), int'(bz[g]), 0);
        end
      end
      dprev <= dn[g];
    end
  end
  task automatic launch(input int t);
    exp_t e;
    @(negedge clk);
    target = 8'(t);
    start = 1;
    e = model(t);
    e.t0 = cyc + 1;
    for (int g = 0; g < 3; g++) q[g].push_back(e);
  endtask
  task automatic wait_all();
    for (int i = 0; i < 300 && (q[0].size() + q[1].size() + q[2].size()) != 0; i++) @(negedge clk);
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      chk("done_timeout", 1, 0);
      for (int g = 0; g < 3; g++) q[g].delete();
    end
  endtask
  task automatic search(input int t);
    launch(t);
    wait_all();
    start = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic chk_reset_vals(input string n);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_mem_addr%0d", n, g), int'(ma[g]), 15);
      chk($sformatf("%s_busy%0d", n, g), int'(bz[g]), 0);
      chk($sformatf("%s_done%0d", n, g), int'(dn[g]), 0);
      chk($sformatf("%s_found%0d", n, g), int'(fd[g]), 0);
      chk($sformatf("%s_result%0d", n, g), int'(ra[g]), 0);
      chk($sformatf("%s_probes%0d", n, g), int'(pr[g]), 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i + 1);
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 0;
    @(negedge clk);
    foreach (ma[g]) chk($sformatf("idle_mem_addr%0d", g), int'(ma[g]), 15);
    search(1);
    search(63);
    search(0);
    search(64);
    search(32);
    launch(31);
    wait_all();
    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("hold_done%0d", g), int'(dn[g]), 1);
    chk("hold_found", int'(fd[0]), 1);
    chk("hold_result", int'(ra[0]), 15);
    chk("hold_probes", int'(pr[0]), 1);
    start = 0;
    @(negedge clk);
    chk("drop_done", int'(dn[0]), 0);
    chk("drop_found", int'(fd[0]), 0);
    chk("drop_result", int'(ra[0]), 0);
    chk("drop_probes_held", int'(pr[0]), 1);
    search(31);
    @(negedge clk);
    target = 1;
    start = 1;
    repeat (2) @(negedge clk);
    chk("abort_pre_busy_lat3", int'(bz[2]), 1);
    abort = 1;
    start = 0;
    @(negedge clk);
    abort = 0;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("abort_busy%0d", g), int'(bz[g]), 0);
      chk($sformatf("abort_done%0d", g), int'(dn[g]), 0);
    end
    chk("abort_probes_lat3", int'(pr[2]), 0);
    chk("abort_mem_addr_lat3", int'(ma[2]), 15);
    for (int n = 0; n < 20; n++) begin
      int v;
      v = $urandom_range(0, 3);
      for (int i = 0; i < 32; i++) begin
        mem[i] = 8'(v);
        v = v + $urandom_range(1, 7);
      end
      for (int k = 0; k < 3; k++) search(($urandom % 2) ? int'(mem[$urandom % 32]) : $urandom_range(0, 255));
    end
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i + 1);
    @(negedge clk);
    target = 1;
    start = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_busy", int'(bz[0]), 1);
    chk("pre_reset_mem_addr", int'(ma[0]), 3);
    chk("pre_reset_probes", int'(pr[0]), 2);
    rst = 1;
    start = 0;
    #1;
    chk_reset_vals("async_reset");
    repeat (2) @(negedge clk);
    rst = 0;
    search(63);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bsearch_sequencer.md
# bsearch_sequencer

Sequencer for a binary search over a sorted, ascending, synchronous-read RAM of 2^ADDR_W words. It owns the low/high bound registers and the probe-address generation. It paces every probe to the RAM read latency and terminates on hit or exhausted range. It sits between the start/target switches and the on-chip RAM, and reports found, the hit address and the probe count to the display logic.

## Interface
- ADDR_W, 5, RAM address width; the searched range is 0 .. 2^ADDR_W-1. Legal values are 1..14.
- DATA_W, 8, data and target width.
- RD_LAT, 1, RAM read latency in cycles, from address sampled to data valid. Legal values are 1..4.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level request; a search begins when start is sampled high in IDLE.
- abort  in  1  synchronous; returns the block to IDLE from any state, with priority over start.
- target  in  DATA_W  value searched for; latched when the search starts.
- mem_addr  out  ADDR_W  RAM read address; equals mid of the current bounds.
- mem_rdata  in  DATA_W  RAM read data; valid RD_LAT cycles after the address is sampled.
- busy  out  1  high in ISSUE, WAIT and COMPARE.
- done  out  1  high in DONE.
- found  out  1  in DONE, 1 means hit and 0 means not found. 0 outside DONE.
- result_addr  out  ADDR_W  hit address when found=1, otherwise 0.
- probes  out  4  number of COMPARE cycles in the current or last search.

## Operation
- Internal registers:
  - low and high are ADDR_W+1 bits wide.
  - mid = (low+high)>>1, computed at ADDR_W+2 bits and truncated to ADDR_W.
  - tgt holds the latched target (DATA_W bits).
  - wcnt is the wait counter.
- States are IDLE, ISSUE, WAIT, COMPARE and DONE.
- IDLE:
  - low=0, high=2^ADDR_W-1, and probes holds its last value.
  - If start=1 and abort=0: latch tgt=target, set probes=0, go to ISSUE.
- ISSUE: lasts one cycle, with mem_addr=mid.
  - RD_LAT=1: go to COMPARE.
  - Otherwise: set wcnt=RD_LAT-1 and go to WAIT.
- WAIT: decrement wcnt each cycle. Go to COMPARE on the cycle wcnt reaches 1. Bounds are frozen, so mem_addr is stable.
- COMPARE: probes increments, saturating at 15. Then:
  - mem_rdata == tgt: result_addr=mid, found=1, go to DONE.
  - mem_rdata > tgt:
    - If mid==0: not found, go to DONE.
    - Otherwise: high=mid-1, then apply the termination check.
  - mem_rdata < tgt: low=mid+1, then apply the termination check.
  - Termination check: if the new low > new high, not found, go to DONE. Otherwise go to ISSUE.
- DONE: found, result_addr and probes are held.
  - Stay while start=1.
  - Go to IDLE when start=0. In IDLE, found and result_addr clear to 0.
  - start must drop before a new search can begin; holding start high never retriggers.
- abort=1 in any state:
  - Next state is IDLE, with found=0 and result_addr=0.
  - probes keeps its partial count.
- Comparisons are unsigned.
- RAM contents are assumed sorted ascending. With unsorted contents the block still terminates within ADDR_W+1 probes, but the result is unspecified.

## Timing
- Reset value of every output:
  - mem_addr = 2^(ADDR_W-1)-1, the mid of the reset bounds.
  - busy, done, found, result_addr and probes are all 0.
  - State is IDLE.
- Reset mid-search takes effect immediately, asynchronously, with the same values.
- Each probe takes RD_LAT+1 cycles.
- done rises (RD_LAT+1)×probes cycles after the edge that samples start.
- The worst case is ADDR_W+1 probes.
- done/found/result_addr change only on clock edges and are registered outputs; busy and done are decoded from state.
- busy and done are never both high.
- If start and abort are both high in IDLE, the block stays in IDLE.

## Test plan
All scenarios use ADDR_W=5, DATA_W=8 and RD_LAT=1 unless stated, with RAM contents mem[i]=2i+1 (the values 1..63).
- target=31 → first probe at address 15 hits. found=1, result_addr=15, probes=1, done 2 cycles after start is sampled.
- target=1 → probe sequence 15,7,3,1,0, then hit. found=1, result_addr=0, probes=5, done after 10 cycles.
- target=63 → probe sequence 15,23,27,29,30,31, then hit. result_addr=31, probes=6, done after 12 cycles. Repeat with RD_LAT=2: done after 18 cycles.
- target=0 → not found via the mid==0 path, probes=5. target=64 → not found via low=32 > high=31, probes=6, no address wrap. target=32 → not found, found=0, result_addr=0.
- Hold start high in DONE for 10 cycles → outputs stable, no retrigger. Drop start → IDLE next cycle with found=0. Raise start again → a new search runs.
- Assert abort during WAIT (RD_LAT=3) → IDLE next cycle with busy=0. Assert reset during COMPARE → all outputs are immediately at their reset values.
